// File: rtl/wb2sram_sp_if.sv
// Wishbone slave and single-port SRAM signal bundle for wb2sram_sp.
// The slave modport is the bridge's view; master is the environment's (WB master plus SRAM).
interface wb2sram_sp_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW      = DW / 8;
  localparam int unsigned WORD_AW = AW - $clog2(SW);

  logic [AW-1:0]      wb_adr_i;
  logic [DW-1:0]      wb_dat_i;
  logic [SW-1:0]      wb_sel_i;
  logic               wb_we_i;
  logic               wb_cyc_i;
  logic               wb_stb_i;
  logic [2:0]         wb_cti_i;
  logic [1:0]         wb_bte_i;
  logic               wb_ack_o;
  logic               wb_err_o;
  logic [DW-1:0]      wb_dat_o;

  logic               sram_ce;
  logic               sram_we;
  logic               sram_oe;
  logic [WORD_AW-1:0] sram_waddr;
  logic [DW-1:0]      sram_din;
  logic [SW-1:0]      sram_sel;
  logic [DW-1:0]      sram_dout;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_ack_o, wb_err_o, wb_dat_o,
    output sram_ce, sram_we, sram_oe, sram_waddr, sram_din, sram_sel,
    input  sram_dout
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_ack_o, wb_err_o, wb_dat_o,
    input  sram_ce, sram_we, sram_oe, sram_waddr, sram_din, sram_sel,
    output sram_dout
  );
endinterface

// File: rtl/wb2sram_sp.sv
// Wishbone slave to single-port synchronous SRAM bridge with registered ack/err.
// Define WB2SRAM_BURST_EN to add incrementing/wrapping bursts; otherwise every access is classic.
module wb2sram_sp #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned MEM_SIZE_BYTE = 32'h8000
) (
  input  logic          clk,
  input  logic          rst,
  wb2sram_sp_if.slave   bus
);

  localparam int unsigned SW      = DW / 8;
  localparam int unsigned BW      = $clog2(SW);
  localparam int unsigned WORD_AW = AW - BW;
  localparam logic [AW:0] ADR_LIM = (AW+1)'(MEM_SIZE_BYTE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    BURST = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic                 r_ack;
  logic                 r_err;
  logic                 w_ack_n;
  logic                 w_err_n;
  logic                 w_ce;
  logic                 w_we;
  logic                 w_oe;
  logic [WORD_AW-1:0]   w_waddr;
  logic [WORD_AW-1:0]   w_adr_word;
  logic                 w_adr_oob;
  logic                 w_req;
  logic                 w_unused;

  assign w_adr_word = bus.wb_adr_i[AW-1:BW];
  assign w_adr_oob  = {1'b0, bus.wb_adr_i} >= ADR_LIM;
  assign w_req      = bus.wb_cyc_i && bus.wb_stb_i;
  // Byte-offset bits never address the SRAM; cti/bte are unused without bursts.
  assign w_unused   = ^{bus.wb_cti_i, bus.wb_bte_i, bus.wb_adr_i};

`ifdef WB2SRAM_BURST_EN
  localparam logic [WORD_AW:0] WADR_LIM = (WORD_AW+1)'(MEM_SIZE_BYTE / SW);

  logic [WORD_AW-1:0] r_waddr;
  logic [WORD_AW-1:0] w_waddr_n;
  logic               w_baddr_oob;

  assign w_baddr_oob = {1'b0, r_waddr} >= WADR_LIM;

  // Increment within a 4/8/16-word window selected by bte; bte=00 is linear.
  function automatic logic [WORD_AW-1:0] wrap_inc(input logic [WORD_AW-1:0] a,
                                                  input logic [1:0]         bte);
    logic [WORD_AW-1:0] inc;
    logic [WORD_AW-1:0] mask;
    inc = a + WORD_AW'(1);
    case (bte)
      2'b01:   mask = WORD_AW'(3);
      2'b10:   mask = WORD_AW'(7);
      2'b11:   mask = WORD_AW'(15);
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
`ifdef WB2SRAM_BURST_EN
      r_waddr <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_ack   <= w_ack_n;
      r_err   <= w_err_n;
`ifdef WB2SRAM_BURST_EN
      r_waddr <= w_waddr_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ack_n   = 1'b0;
    w_err_n   = 1'b0;
    w_ce      = 1'b0;
    w_we      = 1'b0;
    w_oe      = 1'b0;
    w_waddr   = w_adr_word;
`ifdef WB2SRAM_BURST_EN
    w_waddr_n = r_waddr;
`endif
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_adr_oob) begin
            w_err_n   = 1'b1;
            w_state_n = ERR;
          end else begin
            w_ce      = 1'b1;
            w_we      = bus.wb_we_i;
            w_oe      = !bus.wb_we_i;
            w_ack_n   = 1'b1;
            w_state_n = ACK;
`ifdef WB2SRAM_BURST_EN
            if (bus.wb_cti_i == 3'b010) begin
              w_state_n = BURST;
              w_waddr_n = wrap_inc(w_adr_word, bus.wb_bte_i);
            end
`endif
          end
        end
      end
      ACK, ERR: w_state_n = IDLE;
      BURST: begin
`ifdef WB2SRAM_BURST_EN
        // Beat address comes from r_waddr; wb_adr_i is ignored after the first beat.
        w_waddr = r_waddr;
        if (!bus.wb_cyc_i) begin
          w_state_n = IDLE;
        end else if (bus.wb_stb_i) begin
          if (w_baddr_oob) begin
            w_err_n   = 1'b1;
            w_state_n = IDLE;
          end else begin
            w_ce      = 1'b1;
            w_we      = bus.wb_we_i;
            w_oe      = !bus.wb_we_i;
            w_ack_n   = 1'b1;
            w_waddr_n = wrap_inc(r_waddr, bus.wb_bte_i);
            if (bus.wb_cti_i == 3'b111) w_state_n = IDLE;
          end
        end
`else
        w_state_n = IDLE;
`endif
      end
      default: w_state_n = IDLE;
    endcase
    // SRAM strobes stay quiet for the whole time reset is held.
    if (!rst) begin
      w_ce = 1'b0;
      w_we = 1'b0;
      w_oe = 1'b0;
    end
  end

  assign bus.wb_ack_o   = r_ack;
  assign bus.wb_err_o   = r_err;
  assign bus.wb_dat_o   = bus.sram_dout;
  assign bus.sram_ce    = w_ce;
  assign bus.sram_we    = w_we;
  assign bus.sram_oe    = w_oe;
  assign bus.sram_waddr = w_waddr;
  assign bus.sram_din   = bus.wb_dat_i;
  assign bus.sram_sel   = bus.wb_sel_i;

endmodule

// File: tb/tb_wb2sram_sp.sv
// Directed self-checking bench for wb2sram_sp with a registered-read SRAM model.
// Burst scenarios run when WB2SRAM_BURST_EN is defined, the classic-only cti=010 scenario otherwise.
module tb_wb2sram_sp;

  logic        clk;
  logic        rst;
  int          n_checks;
  int          n_errors;
  int          cyc_cnt;
  logic [31:0] rd;
  logic [31:0] mem [0:8191];
`ifdef WB2SRAM_BURST_EN
  int          wseq [4] = '{3, 0, 1, 2};
`else
  int          t0;
`endif

  wb2sram_sp_if #(.AW(32), .DW(32)) bus ();

  wb2sram_sp #(.AW(32), .DW(32), .MEM_SIZE_BYTE(32'h8000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Synchronous SRAM: read data registered, byte-masked writes.
  always @(posedge clk) begin
    if (bus.sram_ce && bus.sram_oe && bus.sram_waddr < 30'd8192)
      bus.sram_dout <= mem[bus.sram_waddr[12:0]];
    if (bus.sram_ce && bus.sram_we && bus.sram_waddr < 30'd8192)
      for (int b = 0; b < 4; b++)
        if (bus.sram_sel[b]) mem[bus.sram_waddr[12:0]][8*b +: 8] <= bus.sram_din[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cti_i = 3'b000;
    bus.wb_bte_i = 2'b00;
  endtask

  // One classic access starting just after a rising edge; leaves the request asserted.
  task automatic wb_xfer(input string tag, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti,
                         output logic [31:0] rdata);
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_cti_i = cti;
    bus.wb_bte_i = 2'b00;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(negedge clk);
    chk({tag, ".ack_k"}, 64'(bus.wb_ack_o), 64'd0);
    chk({tag, ".ce_k"},  64'(bus.sram_ce), 64'd1);
    chk({tag, ".we_k"},  64'(bus.sram_we), 64'(we));
    chk({tag, ".oe_k"},  64'(bus.sram_oe), 64'(!we));
    chk({tag, ".waddr"}, 64'(bus.sram_waddr), 64'(adr >> 2));
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".ack_k1"}, 64'(bus.wb_ack_o), 64'd1);
    chk({tag, ".err_k1"}, 64'(bus.wb_err_o), 64'd0);
    chk({tag, ".ce_k1"},  64'(bus.sram_ce), 64'd0);
    rdata = bus.wb_dat_o;
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc_cnt  = 0;
    rst      = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus_idle();

    // Reset state, and SRAM strobes held low under reset even with a request present.
    #2;
    chk("rst.ack", 64'(bus.wb_ack_o), 64'd0);
    chk("rst.err", 64'(bus.wb_err_o), 64'd0);
    bus.wb_adr_i = 32'h10;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    #1;
    chk("rst.ce", 64'(bus.sram_ce), 64'd0);
    chk("rst.we", 64'(bus.sram_we), 64'd0);
    chk("rst.oe", 64'(bus.sram_oe), 64'd0);
    bus_idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Classic write then back-to-back read, one access per two cycles.
    wb_xfer("wr10", 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, rd);
    wb_xfer("rd10", 32'h10, 1'b0, 32'h0, 4'hF, 3'b000, rd);
    chk("rd10.data", 64'(rd), 64'hDEADBEEF);

    // Single-byte lane update.
    wb_xfer("wrb1", 32'h10, 1'b1, 32'h0000AA00, 4'h2, 3'b111, rd);
    wb_xfer("rdb1", 32'h10, 1'b0, 32'h0, 4'hF, 3'b000, rd);
    chk("rdb1.data", 64'(rd), 64'hDEADAAEF);

    // Last word below the memory limit, and a low-byte merge at word 0.
    wb_xfer("wrtop", 32'h7FFC, 1'b1, 32'h12345678, 4'hF, 3'b000, rd);
    wb_xfer("wr0",   32'h0,    1'b1, 32'hCAFEF00D, 4'hF, 3'b000, rd);
    wb_xfer("wr0b",  32'h0,    1'b1, 32'h000000AB, 4'h1, 3'b000, rd);
    wb_xfer("rdtop", 32'h7FFC, 1'b0, 32'h0, 4'hF, 3'b000, rd);
    chk("rdtop.data", 64'(rd), 64'h12345678);
    wb_xfer("rd0", 32'h0, 1'b0, 32'h0, 4'hF, 3'b000, rd);
    chk("rd0.data", 64'(rd), 64'hCAFEF0AB);
    bus_idle();
    @(posedge clk); #1;

    // Out-of-range read and write: error for one cycle, no ack, no SRAM strobe.
    for (int i = 0; i < 2; i++) begin
      bus.wb_adr_i = (i == 0) ? 32'h8000 : 32'h8004;
      bus.wb_we_i  = (i == 1);
      bus.wb_dat_i = 32'h55AA55AA;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      @(negedge clk);
      chk("oob.ce_k",  64'(bus.sram_ce), 64'd0);
      chk("oob.we_k",  64'(bus.sram_we), 64'd0);
      chk("oob.err_k", 64'(bus.wb_err_o), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("oob.err_k1", 64'(bus.wb_err_o), 64'd1);
      chk("oob.ack_k1", 64'(bus.wb_ack_o), 64'd0);
      chk("oob.ce_k1",  64'(bus.sram_ce), 64'd0);
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk);
      chk("oob.err_k2", 64'(bus.wb_err_o), 64'd0);
      chk("oob.ack_k2", 64'(bus.wb_ack_o), 64'd0);
      @(posedge clk); #1;
    end

    // Strobe without cycle must not touch the SRAM or ack.
    bus.wb_adr_i = 32'h10;
    bus.wb_we_i  = 1'b1;
    bus.wb_dat_i = 32'h0;
    bus.wb_sel_i = 4'hF;
    bus.wb_stb_i = 1'b1;
    @(negedge clk);
    chk("nocyc.ce", 64'(bus.sram_ce), 64'd0);
    chk("nocyc.we", 64'(bus.sram_we), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("nocyc.ack", 64'(bus.wb_ack_o), 64'd0);
    bus_idle();
    @(posedge clk); #1;
    chk("nocyc.mem", 64'(mem[4]), 64'hDEADAAEF);

`ifdef WB2SRAM_BURST_EN
    for (int i = 0; i < 4; i++)
      wb_xfer("bprep", 32'(4 * i), 1'b1, 32'h5A5A0000 + 32'(i), 4'hF, 3'b000, rd);
    bus_idle();
    @(posedge clk); #1;

    // 4-beat wrapping read from word 3: acks on four consecutive cycles.
    bus.wb_adr_i = 32'h0C;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = 4'hF;
    bus.wb_cti_i = 3'b010;
    bus.wb_bte_i = 2'b01;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus.wb_cti_i = 3'b111;
      if (i == 4) bus_idle();
      @(negedge clk);
      if (i < 4) begin
        chk("bst.waddr", 64'(bus.sram_waddr), 64'(wseq[i]));
        chk("bst.ce",    64'(bus.sram_ce), 64'd1);
      end
      chk("bst.ack", 64'(bus.wb_ack_o), 64'(i > 0));
      if (i > 0) chk("bst.data", 64'(bus.wb_dat_o), 64'(32'h5A5A0000 + 32'(wseq[i-1])));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bst.ack_end", 64'(bus.wb_ack_o), 64'd0);
    @(posedge clk); #1;

    // Reset asserted during beat 2 of a wrapping write burst.
    bus.wb_adr_i = 32'h0C;
    bus.wb_we_i  = 1'b1;
    bus.wb_dat_i = 32'hC0DE0003;
    bus.wb_cti_i = 3'b010;
    bus.wb_bte_i = 2'b01;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(negedge clk);
    chk("brst.we_b1", 64'(bus.sram_we), 64'd1);
    @(posedge clk); #1;
    bus.wb_dat_i = 32'hC0DE0000;
    @(negedge clk);
    chk("brst.ack_b1", 64'(bus.wb_ack_o), 64'd1);
    chk("brst.waddr2", 64'(bus.sram_waddr), 64'd0);
    #1 rst = 1'b0;
    #1;
    chk("brst.ack_rst", 64'(bus.wb_ack_o), 64'd0);
    chk("brst.we_rst",  64'(bus.sram_we), 64'd0);
    chk("brst.ce_rst",  64'(bus.sram_ce), 64'd0);
    @(posedge clk); #1;
    bus_idle();
    rst = 1'b1;
    @(negedge clk);
    chk("brst.ack_after", 64'(bus.wb_ack_o), 64'd0);
    @(posedge clk); #1;
    chk("brst.mem3", 64'(mem[3]), 64'hC0DE0003);
    chk("brst.mem0", 64'(mem[0]), 64'h5A5A0000);
    wb_xfer("brst.rd", 32'h0C, 1'b0, 32'h0, 4'hF, 3'b000, rd);
    chk("brst.rd.data", 64'(rd), 64'hC0DE0003);
    bus_idle();
    @(posedge clk); #1;
`else
    // cti=010 without burst support: four classic beats, eight cycles.
    t0 = cyc_cnt;
    for (int i = 0; i < 4; i++)
      wb_xfer("cb", 32'h20 + 32'(4 * i), 1'b1, 32'hB0000000 + 32'(i), 4'hF,
              (i == 3) ? 3'b111 : 3'b010, rd);
    chk("cb.cycles", 64'(cyc_cnt - t0), 64'd8);
    bus_idle();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      chk("cb.mem", 64'(mem[8 + i]), 64'(32'hB0000000 + 32'(i)));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
